// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Boot-time program loader. It holds the CPU idle, takes a little-endian byte
//   stream made of a word-count header, N instruction words and one data word,
//   and writes them into instruction memory (addresses 0..N-1) and data memory
//   (word at byte address 0x00). It then releases the CPU. A load request while
//   the CPU runs starts a fresh session.
//
// Configuration:
//   PROGRAM_LOADER_CLEAR_EN - when defined, instruction words N..IMEM_DEPTH-1
//                             are zero-filled after the program is written.
//                             When undefined, those words are left untouched.
//
// Parameters:
//   IMEM_DEPTH    instruction-memory depth in 32-bit words (power of two, 2..256)
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_i         asynchronous, active-high reset
//   load_i        request to begin a load session (seen in IDLE and RUN only)
//   byte_valid_i  incoming byte is valid
//   byte_data_i   incoming byte
//   byte_ready_o  loader can take a byte this cycle
//   imem_we_o     instruction-memory word write strobe
//   imem_addr_o   instruction-memory word address
//   imem_data_o   instruction-memory write data
//   dmem_we_o     data-memory write strobe (word at byte address 0x00)
//   dmem_data_o   data-memory write data
//   cpu_hold_o    CPU held idle (low only while running)
//   start_o       CPU start (high only while running)
//   busy_o        load session in progress
// -----------------------------------------------------------------------------
`default_nettype none

module program_loader #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_i,
    input  logic                          byte_valid_i,
    input  logic [7:0]                    byte_data_i,
    output logic                          byte_ready_o,
    output logic                          imem_we_o,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr_o,
    output logic [31:0]                   imem_data_o,
    output logic                          dmem_we_o,
    output logic [31:0]                   dmem_data_o,
    output logic                          cpu_hold_o,
    output logic                          start_o,
    output logic                          busy_o
);

    localparam int              AW        = $clog2(IMEM_DEPTH);
    localparam logic [8:0]      DEPTH9    = 9'(IMEM_DEPTH);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(IMEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_INSTR,
`ifdef PROGRAM_LOADER_CLEAR_EN
        S_CLEAR,
`endif
        S_DATA,
        S_RUN
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [AW-1:0] addr;        // word index being filled or cleared
    logic [1:0]    byte_cnt;    // byte position inside the current word
    logic [23:0]   word_buf;    // lower three bytes of the word being assembled
    logic [8:0]    n_words;     // effective instruction word count, 1..IMEM_DEPTH
    logic [8:0]    hdr_count;
    logic          can_take;
    logic          byte_accept;
    logic          last_word;

    // Header of 0 means a full memory; anything beyond the depth is clamped.
    assign hdr_count = (byte_data_i == 8'd0 || {1'b0, byte_data_i} > DEPTH9)
                     ? DEPTH9 : {1'b0, byte_data_i};

    assign last_word = ({{(9 - AW){1'b0}}, addr} == n_words - 9'd1);

    // The byte slot closes for the cycle in which a registered write is on the
    // memory ports, which is what keeps the write exactly one cycle after the
    // fourth byte without needing a second word buffer.
    assign can_take     = (state == S_HDR || state == S_INSTR || state == S_DATA)
                        && !imem_we_o && !dmem_we_o;
    assign byte_ready_o = can_take;
    assign byte_accept  = byte_valid_i && can_take;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples its inputs from before the edge, regardless of block order.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        next_state = state;
        busy_o     = 1'b0;
        cpu_hold_o = 1'b1;
        start_o    = 1'b0;

        case (state)
            S_IDLE: begin
                if (load_i) next_state = S_HDR;
            end
            S_HDR: begin
                busy_o = 1'b1;
                if (byte_accept) next_state = S_INSTR;
            end
            S_INSTR: begin
                busy_o = 1'b1;
                if (byte_accept && byte_cnt == 2'd3 && last_word) begin
`ifdef PROGRAM_LOADER_CLEAR_EN
                    next_state = (n_words < DEPTH9) ? S_CLEAR : S_DATA;
`else
                    next_state = S_DATA;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CLEAR_EN
            S_CLEAR: begin
                busy_o = 1'b1;
                if (addr == LAST_ADDR) next_state = S_DATA;
            end
`endif
            S_DATA: begin
                busy_o = 1'b1;
                if (byte_accept && byte_cnt == 2'd3) next_state = S_RUN;
            end
            S_RUN: begin
                cpu_hold_o = 1'b0;
                start_o    = 1'b1;
                if (load_i) next_state = S_HDR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: counters, word assembly and the registered memory write ports.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr        <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
            n_words     <= '0;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            dmem_we_o   <= 1'b0;
            dmem_data_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            dmem_we_o <= 1'b0;

            // Bytes arrive LSB first, so shifting in from the top leaves the
            // first three bytes in little-endian order when the fourth arrives.
            if (byte_accept) word_buf <= {byte_data_i, word_buf[23:8]};

            case (state)
                S_IDLE, S_RUN: begin
                    if (load_i) begin
                        addr     <= '0;
                        byte_cnt <= '0;
                    end
                end
                S_HDR: begin
                    if (byte_accept) n_words <= hdr_count;
                end
                S_INSTR: begin
                    if (byte_accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we_o   <= 1'b1;
                            imem_addr_o <= addr;
                            imem_data_o <= {byte_data_i, word_buf};
                            // Saturate at the top so a full-depth load never
                            // wraps back to address 0.
                            if (addr != LAST_ADDR) addr <= addr + 1'b1;
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CLEAR_EN
                S_CLEAR: begin
                    imem_we_o   <= 1'b1;
                    imem_addr_o <= addr;
                    imem_data_o <= '0;
                    if (addr != LAST_ADDR) addr <= addr + 1'b1;
                end
`endif
                S_DATA: begin
                    if (byte_accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            dmem_we_o   <= 1'b1;
                            dmem_data_o <= {byte_data_i, word_buf};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. A bench-side instruction and data
// memory are written only by the DUT's write ports; a reference image of what
// they should hold is computed from the header/word stream independently.
// Honours PROGRAM_LOADER_CLEAR_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_program_loader;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic          bvalid;
    logic [7:0]    bdata;
    logic          ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          dmem_we;
    logic [31:0]   dmem_data;
    logic          hold;
    logic          start;
    logic          busy;

    always #5 clk = ~clk;

    program_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (load),
        .byte_valid_i (bvalid),
        .byte_data_i  (bdata),
        .byte_ready_o (ready),
        .imem_we_o    (imem_we),
        .imem_addr_o  (imem_addr),
        .imem_data_o  (imem_data),
        .dmem_we_o    (dmem_we),
        .dmem_data_o  (dmem_data),
        .cpu_hold_o   (hold),
        .start_o      (start),
        .busy_o       (busy)
    );

    int          n_vec = 0;
    int          n_bad = 0;

    logic [31:0] tb_imem  [DEPTH];   // memory as written by the DUT
    logic [31:0] exp_imem [DEPTH];   // reference image
    logic [31:0] tb_dmem;
    logic [31:0] exp_dmem;
    int          imem_wr;
    int          dmem_wr;
    int          wr_addr_q[$];

    logic [31:0] stim_words [DEPTH];
    logic [31:0] stim_data;
    bit          phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_now();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "bench aborted");
    endtask

    // Memory-side observer: captures every write the DUT issues.
    always @(negedge clk) begin
        if (imem_we) begin
            check("ready_during_imem_we", ready, 1'b0);
            tb_imem[imem_addr] = imem_data;
            wr_addr_q.push_back(int'(imem_addr));
            imem_wr++;
        end
        if (dmem_we) begin
            check("ready_during_dmem_we", ready, 1'b0);
            tb_dmem = dmem_data;
            dmem_wr++;
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"},   ready,   1'b0);
        check({pfx, "_imem_we"}, imem_we, 1'b0);
        check({pfx, "_dmem_we"}, dmem_we, 1'b0);
        check({pfx, "_start"},   start,   1'b0);
        check({pfx, "_busy"},    busy,    1'b0);
        check({pfx, "_hold"},    hold,    1'b1);
    endtask

    // gap_mode: 0 = valid every cycle, 1 = valid on alternate cycles, 2 = random
    task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit noise);
        bit acc = 1'b0;
        int cycles = 0;
        while (!acc) begin
            @(negedge clk);
            case (gap_mode)
                0:       bvalid = 1'b1;
                1:       begin bvalid = phase; phase = ~phase; end
                default: bvalid = ($urandom_range(0, 3) != 0);
            endcase
            bdata = bvalid ? b : 8'($urandom);
            if (noise) load = 1'($urandom_range(0, 1));
            acc = bvalid && ready;
            @(posedge clk);
            cycles++;
            if (!acc && cycles > 64) begin
                check("byte_accept_timeout", 32'd0, 32'd1);
                finish_now();
            end
        end
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load = 1'b1;
        @(posedge clk);
        #1;
        check("start_after_load", start, 1'b0);
        check("hold_after_load",  hold,  1'b1);
        check("busy_after_load",  busy,  1'b1);
        load = 1'b0;
    endtask

    // One complete session using stim_words/stim_data; compares the captured
    // memories against the reference image afterwards.
    task automatic run_session(input logic [7:0] hdr, input int gap_mode, input bit noise);
        int n;
        int exp_wr;
        int bad;
        int cycles;
        n = (hdr == 8'd0 || int'(hdr) > DEPTH) ? DEPTH : int'(hdr);
        imem_wr = 0;
        dmem_wr = 0;
        wr_addr_q.delete();

        pulse_load();
        send_byte(hdr, gap_mode, noise);
        for (int k = 0; k < n; k++)
            for (int j = 0; j < 4; j++)
                send_byte(stim_words[k][8*j +: 8], gap_mode, noise);
        load = 1'b0;
        check("busy_before_data", busy, 1'b1);
        for (int j = 0; j < 4; j++)
            send_byte(stim_data[8*j +: 8], gap_mode, 1'b0);
        @(negedge clk);
        bvalid = 1'b0;
        cycles = 0;
        while (!start && cycles < 600) begin
            @(negedge clk);
            cycles++;
        end
        check("start_reached", start, 1'b1);
        @(negedge clk);
        check("run_start", start, 1'b1);
        check("run_hold",  hold,  1'b0);
        check("run_busy",  busy,  1'b0);
        check("run_ready", ready, 1'b0);

        for (int k = 0; k < n; k++) exp_imem[k] = stim_words[k];
`ifdef PROGRAM_LOADER_CLEAR_EN
        for (int k = n; k < DEPTH; k++) exp_imem[k] = 32'h0;
        exp_wr = DEPTH;
`else
        exp_wr = n;
`endif
        exp_dmem = stim_data;

        check("imem_write_count", imem_wr, exp_wr);
        check("dmem_write_count", dmem_wr, 1);
        bad = 0;
        foreach (wr_addr_q[i]) if (wr_addr_q[i] != i) bad++;
        check("imem_addr_sequence_errors", bad, 0);
        for (int k = 0; k < DEPTH; k++)
            check($sformatf("imem[%0d]", k), tb_imem[k], exp_imem[k]);
        check("dmem_word0", tb_dmem, exp_dmem);
    endtask

    task automatic randomize_words();
        for (int k = 0; k < DEPTH; k++) stim_words[k] = $urandom;
        stim_data = $urandom;
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b0;
        bvalid = 1'b0;
        bdata  = 8'h00;
        phase  = 1'b0;
        imem_wr = 0;
        dmem_wr = 0;
        for (int k = 0; k < DEPTH; k++) begin
            tb_imem[k]  = 32'hFFFF_FFFF;
            exp_imem[k] = 32'hFFFF_FFFF;
        end
        tb_dmem  = 32'h0;
        exp_dmem = 32'h0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Bytes offered in IDLE must be refused.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bvalid = 1'b1;
            bdata  = 8'($urandom);
            check("idle_ready", ready, 1'b0);
            check("idle_busy",  busy,  1'b0);
        end
        @(negedge clk);
        bvalid = 1'b0;
        check("idle_imem_writes", imem_wr, 0);
        check("idle_dmem_writes", dmem_wr, 0);

        // Reference program, back-to-back bytes, then with alternate-cycle gaps.
        stim_words[0] = 32'h0000_0513;
        stim_words[1] = 32'h0015_0593;
        stim_data     = 32'h0000_0005;
        run_session(8'd2, 0, 1'b0);
        check("ref_imem0", tb_imem[0], 32'h0000_0513);
        check("ref_imem1", tb_imem[1], 32'h0015_0593);
        check("ref_dmem",  tb_dmem,    32'h0000_0005);
        run_session(8'd2, 1, 1'b0);
        check("gap_total_writes", imem_wr + dmem_wr, 3 + DEPTH - 2 -
`ifdef PROGRAM_LOADER_CLEAR_EN
              0
`else
              (DEPTH - 2)
`endif
             );

        // Reset after the second byte of word 0 abandons the session.
        imem_wr = 0;
        dmem_wr = 0;
        pulse_load();
        send_byte(8'd2,  0, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        @(negedge clk);
        bvalid = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bvalid = 1'b1;
            check("post_reset_ready", ready, 1'b0);
            check("post_reset_busy",  busy,  1'b0);
        end
        @(negedge clk);
        bvalid = 1'b0;
        check("midreset_imem_writes", imem_wr, 0);
        check("midreset_dmem_writes", dmem_wr, 0);

        // Fresh session after reset, random gaps, load_i toggling mid-session.
        randomize_words();
        run_session(8'd3, 2, 1'b1);

        // Reload from RUN with a full-depth header.
        randomize_words();
        run_session(8'd0, 2, 1'b0);

        // Random lengths, including the largest header byte.
        randomize_words();
        run_session(8'd255, 0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            randomize_words();
            run_session(8'($urandom_range(1, 255)), 2, 1'b1);
        end
        randomize_words();
        run_session(8'd1, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
